// File: rtl/vt_pkg.sv
// Shared count width, default timing constants and window decode helper
// for the video timing generator.
package vt_pkg;

    localparam int CNT_W = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    localparam cnt_t H_LOAD_DEF       = 9'h080;
    localparam cnt_t H_ACT_START_DEF  = 9'h0C0;
    localparam cnt_t H_ACT_END_DEF    = 9'h1C0;
    localparam cnt_t H_SYNC_START_DEF = 9'h1D0;
    localparam cnt_t H_SYNC_END_DEF   = 9'h1F0;

    localparam cnt_t V_LOAD_DEF       = 9'h0F8;
    localparam cnt_t V_ACT_START_DEF  = 9'h110;
    localparam cnt_t V_ACT_END_DEF    = 9'h1F0;
    localparam cnt_t V_SYNC_START_DEF = 9'h1F0;
    localparam cnt_t V_SYNC_END_DEF   = 9'h1F8;

    // Half-open window test: lo <= x < hi.
    function automatic logic in_win(cnt_t x, cnt_t lo, cnt_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/cen_edge_det.sv
// Rising-edge detector for the pixel clock-enable. History resets to 1 so a
// Cen already high when reset releases is not taken as an edge.
module cen_edge_det (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Cen,
    output logic adv
);

    logic cen_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cen_q <= 1'b1;
        end else begin
            cen_q <= Cen;
        end
    end

    assign adv = Cen & ~cen_q;

endmodule

// File: rtl/video_timing_gen.sv
// Horizontal/vertical timing counters with registered blank, sync and
// wrap-pulse decodes that change on the same edge as the counts.
module video_timing_gen
    import vt_pkg::*;
#(
    parameter cnt_t H_LOAD       = H_LOAD_DEF,
    parameter cnt_t H_ACT_START  = H_ACT_START_DEF,
    parameter cnt_t H_ACT_END    = H_ACT_END_DEF,
    parameter cnt_t H_SYNC_START = H_SYNC_START_DEF,
    parameter cnt_t H_SYNC_END   = H_SYNC_END_DEF,
    parameter cnt_t V_LOAD       = V_LOAD_DEF,
    parameter cnt_t V_ACT_START  = V_ACT_START_DEF,
    parameter cnt_t V_ACT_END    = V_ACT_END_DEF,
    parameter cnt_t V_SYNC_START = V_SYNC_START_DEF,
    parameter cnt_t V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Cen,
    input  logic             Clear_bar,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             HBLANK,
    output logic             VBLANK,
    output logic             HSYNC_n,
    output logic             VSYNC_n,
    output logic             LINE_END,
    output logic             FRAME_END
);

    logic adv;

    cen_edge_det u_cen_edge_det (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Cen   (Cen),
        .adv   (adv)
    );

    cnt_t hcnt_q, hcnt_d;
    cnt_t vcnt_q, vcnt_d;
    logic hblank_q, hblank_d;
    logic vblank_q, vblank_d;
    logic hsync_n_q, hsync_n_d;
    logic vsync_n_q, vsync_n_d;
    logic line_end_q, line_end_d;
    logic frame_end_q, frame_end_d;

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;

        // Clear has priority over any advance in the same cycle.
        if (!Clear_bar) begin
            hcnt_d = H_LOAD;
            vcnt_d = V_LOAD;
        end else if (adv) begin
            if (hcnt_q == CNT_MAX) begin
                hcnt_d     = H_LOAD;
                line_end_d = 1'b1;
                if (vcnt_q == CNT_MAX) begin
                    vcnt_d      = V_LOAD;
                    frame_end_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 9'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
        end

        // Decodes look at the next count so they register alongside it.
        hblank_d  = ~in_win(hcnt_d, H_ACT_START, H_ACT_END);
        vblank_d  = ~in_win(vcnt_d, V_ACT_START, V_ACT_END);
        hsync_n_d = ~in_win(hcnt_d, H_SYNC_START, H_SYNC_END);
        vsync_n_d = ~in_win(vcnt_d, V_SYNC_START, V_SYNC_END);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hcnt_q      <= H_LOAD;
            vcnt_q      <= V_LOAD;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign HCNT      = hcnt_q;
    assign VCNT      = vcnt_q;
    assign HBLANK    = hblank_q;
    assign VBLANK    = vblank_q;
    assign HSYNC_n   = hsync_n_q;
    assign VSYNC_n   = vsync_n_q;
    assign LINE_END  = line_end_q;
    assign FRAME_END = frame_end_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: u0 uses default timing, u1 uses 16-advance
// lines (default V) so whole frames and deep V positions are quick to reach.
module tb_video_timing_gen;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Cen;
    logic       Clear_bar;
    logic [8:0] hcnt_w [2];
    logic [8:0] vcnt_w [2];
    logic       hb_w [2];
    logic       vb_w [2];
    logic       hs_w [2];
    logic       vs_w [2];
    logic       le_w [2];
    logic       fe_w [2];

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    video_timing_gen u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Cen(Cen), .Clear_bar(Clear_bar),
        .HCNT(hcnt_w[0]), .VCNT(vcnt_w[0]), .HBLANK(hb_w[0]), .VBLANK(vb_w[0]),
        .HSYNC_n(hs_w[0]), .VSYNC_n(vs_w[0]), .LINE_END(le_w[0]), .FRAME_END(fe_w[0])
    );

    video_timing_gen #(
        .H_LOAD(9'h1F0), .H_ACT_START(9'h1F4), .H_ACT_END(9'h1FC),
        .H_SYNC_START(9'h1FD), .H_SYNC_END(9'h1FF)
    ) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Cen(Cen), .Clear_bar(Clear_bar),
        .HCNT(hcnt_w[1]), .VCNT(vcnt_w[1]), .HBLANK(hb_w[1]), .VBLANK(vb_w[1]),
        .HSYNC_n(hs_w[1]), .VSYNC_n(vs_w[1]), .LINE_END(le_w[1]), .FRAME_END(fe_w[1])
    );

    // Reference model parameters, one entry per instance.
    int p_hl  [2] = '{'h080, 'h1F0};
    int p_has [2] = '{'h0C0, 'h1F4};
    int p_hae [2] = '{'h1C0, 'h1FC};
    int p_hss [2] = '{'h1D0, 'h1FD};
    int p_hse [2] = '{'h1F0, 'h1FF};
    int p_vl  = 'h0F8;
    int p_vas = 'h110;
    int p_vae = 'h1F0;
    int p_vss = 'h1F0;
    int p_vse = 'h1F8;

    int m_h [2];
    int m_v [2];
    bit m_hb [2], m_vb [2], m_hs [2], m_vs [2], m_le [2], m_fe [2];
    bit m_prev;
    bit m_adv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_h[i] = p_hl[i];
            m_v[i] = p_vl;
            m_hb[i] = 1; m_vb[i] = 1; m_hs[i] = 1; m_vs[i] = 1;
            m_le[i] = 0; m_fe[i] = 0;
        end
        m_prev = 1;
    endtask

    task automatic model_edge(input bit c, input bit clr_n);
        m_adv  = c && !m_prev;
        m_prev = c;
        for (int i = 0; i < 2; i++) begin
            m_le[i] = 0;
            m_fe[i] = 0;
            if (!clr_n) begin
                m_h[i] = p_hl[i];
                m_v[i] = p_vl;
            end else if (m_adv) begin
                if (m_h[i] == 511) begin
                    m_h[i] = p_hl[i];
                    m_le[i] = 1;
                    if (m_v[i] == 511) begin
                        m_v[i] = p_vl;
                        m_fe[i] = 1;
                    end else begin
                        m_v[i] = m_v[i] + 1;
                    end
                end else begin
                    m_h[i] = m_h[i] + 1;
                end
            end
            m_hb[i] = !(m_h[i] >= p_has[i] && m_h[i] < p_hae[i]);
            m_hs[i] = !(m_h[i] >= p_hss[i] && m_h[i] < p_hse[i]);
            m_vb[i] = !(m_v[i] >= p_vas && m_v[i] < p_vae);
            m_vs[i] = !(m_v[i] >= p_vss && m_v[i] < p_vse);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_hcnt%0d", tag, i), 32'(hcnt_w[i]), m_h[i]);
            chk($sformatf("%s_vcnt%0d", tag, i), 32'(vcnt_w[i]), m_v[i]);
            chk($sformatf("%s_hblank%0d", tag, i), 32'(hb_w[i]), 32'(m_hb[i]));
            chk($sformatf("%s_vblank%0d", tag, i), 32'(vb_w[i]), 32'(m_vb[i]));
            chk($sformatf("%s_hsync%0d", tag, i), 32'(hs_w[i]), 32'(m_hs[i]));
            chk($sformatf("%s_vsync%0d", tag, i), 32'(vs_w[i]), 32'(m_vs[i]));
            chk($sformatf("%s_le%0d", tag, i), 32'(le_w[i]), 32'(m_le[i]));
            chk($sformatf("%s_fe%0d", tag, i), 32'(fe_w[i]), 32'(m_fe[i]));
        end
    endtask

    task automatic step(input bit c, input bit clr_n);
        Cen = c;
        Clear_bar = clr_n;
        @(posedge Clk);
        model_edge(c, clr_n);
        #1;
        check_all("step");
    endtask

    task automatic walk_h0(input int tgt);
        int n = 0;
        while (m_h[0] != tgt && n < 1000) begin
            step(0, 1);
            step(1, 1);
            n++;
        end
    endtask

    task automatic walk_v1(input int tgt);
        int n = 0;
        while (m_v[1] != tgt && n < 6000) begin
            step(0, 1);
            step(1, 1);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hcnt0"}, 32'(hcnt_w[0]), 32'h080);
        chk({tag, "_hcnt1"}, 32'(hcnt_w[1]), 32'h1F0);
        chk({tag, "_vcnt0"}, 32'(vcnt_w[0]), 32'h0F8);
        chk({tag, "_hblank"}, 32'(hb_w[0]), 1);
        chk({tag, "_vblank"}, 32'(vb_w[0]), 1);
        chk({tag, "_hsync"}, 32'(hs_w[0]), 1);
        chk({tag, "_vsync"}, 32'(vs_w[0]), 1);
        chk({tag, "_le"}, 32'(le_w[0]), 0);
        chk({tag, "_fe"}, 32'(fe_w[0]), 0);
    endtask

    initial begin
        #3ms;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int adv_cnt, fe_cnt, both_cnt, changes, n;
        logic [8:0] prev_h;

        // Reset state
        Rst_n = 0; Cen = 0; Clear_bar = 1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        check_all("reset");
        @(negedge Clk) Rst_n = 1;

        // One advance per two Clk; a full default line wraps to 080 / 0F9
        step(0, 1);
        step(1, 1);
        chk("first_adv_hcnt", 32'(hcnt_w[0]), 32'h081);
        for (int k = 1; k < 384; k++) begin
            step(0, 1);
            step(1, 1);
        end
        chk("line_hcnt", 32'(hcnt_w[0]), 32'h080);
        chk("line_vcnt", 32'(vcnt_w[0]), 32'h0F9);
        chk("line_le_hi", 32'(le_w[0]), 1);
        step(0, 1);
        chk("line_le_lo", 32'(le_w[0]), 0);

        // Horizontal decode boundaries on u0
        walk_h0('h0BF); chk("hb_0bf", 32'(hb_w[0]), 1); chk("at_0bf", 32'(hcnt_w[0]), 32'h0BF);
        walk_h0('h0C0); chk("hb_0c0", 32'(hb_w[0]), 0);
        walk_h0('h1BF); chk("hb_1bf", 32'(hb_w[0]), 0);
        walk_h0('h1C0); chk("hb_1c0", 32'(hb_w[0]), 1);
        walk_h0('h1CF); chk("hs_1cf", 32'(hs_w[0]), 1);
        walk_h0('h1D0); chk("hs_1d0", 32'(hs_w[0]), 0);
        walk_h0('h1EF); chk("hs_1ef", 32'(hs_w[0]), 0);
        walk_h0('h1F0); chk("hs_1f0", 32'(hs_w[0]), 1); chk("at_1f0", 32'(hcnt_w[0]), 32'h1F0);

        // One full frame on u1: 264 lines x 16 advances, random Cen gaps
        step(0, 0);
        adv_cnt = 0; fe_cnt = 0; both_cnt = 0; n = 0;
        while (adv_cnt < 264 * 16 && n < 30000) begin
            step(1'($urandom_range(0, 1)), 1);
            if (m_adv) adv_cnt++;
            if (fe_w[1]) fe_cnt++;
            if (fe_w[1] && le_w[1]) both_cnt++;
            n++;
        end
        chk("frame_adv_count", adv_cnt, 264 * 16);
        chk("frame_vcnt", 32'(vcnt_w[1]), 32'h0F8);
        chk("frame_hcnt", 32'(hcnt_w[1]), 32'h1F0);
        chk("frame_fe_pulses", fe_cnt, 1);
        chk("frame_fe_with_le", both_cnt, 1);

        // Vertical decode boundaries on u1
        walk_v1('h10F); chk("vb_10f", 32'(vb_w[1]), 1); chk("at_10f", 32'(vcnt_w[1]), 32'h10F);
        walk_v1('h110); chk("vb_110", 32'(vb_w[1]), 0);
        walk_v1('h1EF); chk("vb_1ef", 32'(vb_w[1]), 0); chk("vs_1ef", 32'(vs_w[1]), 1);
        walk_v1('h1F0); chk("vb_1f0", 32'(vb_w[1]), 1); chk("vs_1f0", 32'(vs_w[1]), 0);
        walk_v1('h1F7); chk("vs_1f7", 32'(vs_w[1]), 0);
        walk_v1('h1F8); chk("vs_1f8", 32'(vs_w[1]), 1); chk("at_1f8", 32'(vcnt_w[1]), 32'h1F8);

        // Random Cen with occasional clears
        for (int k = 0; k < 2000; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0));
        end

        // Clear coincident with an advance at HCNT=150
        step(1, 1);
        walk_h0('h150);
        step(0, 1);
        chk("clr_pre_hcnt", 32'(hcnt_w[0]), 32'h150);
        step(1, 0);
        chk("clr_hcnt", 32'(hcnt_w[0]), 32'h080);
        chk("clr_vcnt", 32'(vcnt_w[0]), 32'h0F8);
        chk("clr_le", 32'(le_w[0]), 0);

        // Cen held through clear release gives no advance
        step(1, 1);
        chk("clr_release_hcnt", 32'(hcnt_w[0]), 32'h080);

        // Cen held high for 50 Clk: exactly one advance
        step(0, 1);
        prev_h = hcnt_w[0];
        changes = 0;
        repeat (50) begin
            step(1, 1);
            if (hcnt_w[0] !== prev_h) changes++;
            prev_h = hcnt_w[0];
        end
        chk("hold_changes", changes, 1);

        // Async reset between edges at HCNT=1FF
        walk_h0('h1FF);
        chk("pre_rst_hcnt", 32'(hcnt_w[0]), 32'h1FF);
        #3 Rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge Clk);
        #1;
        check_reset_outputs("rst_held");
        @(negedge Clk) Rst_n = 1;

        // Cen high on first cycle after release must not advance
        step(1, 1);
        chk("post_rst_noadv", 32'(hcnt_w[0]), 32'h080);
        step(0, 1);
        step(1, 1);
        chk("post_rst_adv", 32'(hcnt_w[0]), 32'h081);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
